// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled start/data/parity/stop decoding with error flags.
// Latency: 2 clocks sync + ticks to mid-stop-bit + 1 clock to o_rx_done.
// Backpressure: none; o_rx_done is a 1-clock pulse and the consumer must accept it.
//
// Ports:
//   i_clock      system clock (rising edge)
//   i_reset      asynchronous reset, active-low
//   i_rate       1-clock baud-tick enable, OVERSAMPLE ticks per bit
//   i_bit_rx     serial line, idle high, asynchronous to i_clock
//   o_rx_done    1-clock pulse, frame complete; data/err outputs valid
//   o_data_out   received word, LSB = first data bit
//   o_parity_err parity mismatch on last frame (always 0 when PARITY_MODE=0)
//   o_frame_err  a stop bit sampled 0 on last frame
//   o_busy       high while the FSM is not IDLE
module uart_rx_param #(
  parameter int WIDTH_WORD    = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int PARITY_MODE   = 0,
  parameter int CANT_BIT_STOP = 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rate,
  input  logic                  i_bit_rx,
  output logic                  o_rx_done,
  output logic [WIDTH_WORD-1:0] o_data_out,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_busy
);

  localparam int TW = $clog2(OVERSAMPLE) + 1;
  localparam int BW = $clog2(WIDTH_WORD) + 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH_WORD - 1);
  localparam logic [1:0]    STOP_LAST = 2'(CANT_BIT_STOP - 1);
  localparam logic          PAR_ODD   = (PARITY_MODE == 2);
  localparam logic          PAR_EN    = (PARITY_MODE != 0);

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]            stop_cnt_q, stop_cnt_d;
  logic [WIDTH_WORD-1:0] shreg_q, shreg_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  armed_q, armed_d;
  logic                  done_q, done_d;
  logic [WIDTH_WORD-1:0] data_out_q, data_out_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;

  logic rxs;
  logic mid_bit;

  assign rxs     = sync2_q;
  assign mid_bit = (tick_cnt_q == TICK_MID);

  always_comb begin
    sync1_d      = i_bit_rx;
    sync2_d      = sync1_q;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    armed_d      = armed_q;
    done_d       = 1'b0;
    data_out_d   = data_out_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (i_rate) begin
      case (state_q)
        S_IDLE: begin
          // After a frame whose final stop bit was 0 (e.g. a break) the line
          // must return high before another falling edge counts as a start.
          if (!armed_q) begin
            if (rxs) armed_d = 1'b1;
          end else if (!rxs) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end

        S_START: begin
          if (tick_cnt_q == TICK_HALF) begin
            if (rxs) begin
              state_d    = S_IDLE;  // glitch, not a real start bit
              tick_cnt_d = '0;
            end else begin
              state_d    = S_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              perr_d     = 1'b0;
              ferr_d     = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        S_DATA: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            shreg_d    = {rxs, shreg_q[WIDTH_WORD-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d  = '0;
              stop_cnt_d = '0;
              state_d    = PAR_EN ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        S_PARITY: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            perr_d     = rxs ^ (^shreg_q) ^ PAR_ODD;
            state_d    = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        S_STOP: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            ferr_d     = ferr_q | ~rxs;
            if (stop_cnt_q == STOP_LAST) begin
              // Leave at mid stop bit so a start bit right behind is caught.
              state_d      = S_IDLE;
              stop_cnt_d   = '0;
              armed_d      = rxs;
              done_d       = 1'b1;
              data_out_d   = shreg_q;
              parity_err_d = perr_q;
              frame_err_d  = ferr_q | ~rxs;
            end else begin
              stop_cnt_d = stop_cnt_q + 2'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end

        default: begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= '0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      armed_q      <= 1'b1;
      done_q       <= 1'b0;
      data_out_q   <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      armed_q      <= armed_d;
      done_q       <= done_d;
      data_out_q   <= data_out_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign o_rx_done    = done_q;
  assign o_data_out   = data_out_q;
  assign o_parity_err = parity_err_q;
  assign o_frame_err  = frame_err_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 8N2) sharing clock, tick and reset.
// Baud tick fires every other clock, so one bit lasts 32 clocks at OVERSAMPLE=16.
// Expected frames are queued as they are sent and matched on each o_rx_done pulse.
module tb_uart_rx_param;

  localparam int BIT_CLK = 32;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rate = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

  logic       done0, done1, done2;
  logic [7:0] data0, data1, data2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;
  logic       busy0, busy1, busy2;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;

  uart_rx_param #(.WIDTH_WORD(8), .OVERSAMPLE(16), .PARITY_MODE(0), .CANT_BIT_STOP(1)) u_dut0 (
    .i_clock(clk), .i_reset(rst_n), .i_rate(rate), .i_bit_rx(rx0),
    .o_rx_done(done0), .o_data_out(data0), .o_parity_err(perr0),
    .o_frame_err(ferr0), .o_busy(busy0)
  );

  uart_rx_param #(.WIDTH_WORD(8), .OVERSAMPLE(16), .PARITY_MODE(1), .CANT_BIT_STOP(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst_n), .i_rate(rate), .i_bit_rx(rx1),
    .o_rx_done(done1), .o_data_out(data1), .o_parity_err(perr1),
    .o_frame_err(ferr1), .o_busy(busy1)
  );

  uart_rx_param #(.WIDTH_WORD(8), .OVERSAMPLE(16), .PARITY_MODE(0), .CANT_BIT_STOP(2)) u_dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_rate(rate), .i_bit_rx(rx2),
    .o_rx_done(done2), .o_data_out(data2), .o_parity_err(perr2),
    .o_frame_err(ferr2), .o_busy(busy2)
  );

  initial begin
    forever begin
      #5 clk = 1'b1;
      #5 clk = 1'b0;
      rate = ~rate;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    return e;
  endfunction

  // Scoreboard: every done pulse must be single-cycle and match the oldest queued frame.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done0) begin
        check("d0_pulse_width", {31'd0, prev0}, 32'd0);
        check("d0_done_expected", {31'd0, q0.size() != 0}, 32'd1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          check("d0_data", {24'd0, data0}, {24'd0, e.data});
          check("d0_perr", {31'd0, perr0}, {31'd0, e.perr});
          check("d0_ferr", {31'd0, ferr0}, {31'd0, e.ferr});
        end
      end
      if (done1) begin
        check("d1_pulse_width", {31'd0, prev1}, 32'd0);
        check("d1_done_expected", {31'd0, q1.size() != 0}, 32'd1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          check("d1_data", {24'd0, data1}, {24'd0, e.data});
          check("d1_perr", {31'd0, perr1}, {31'd0, e.perr});
          check("d1_ferr", {31'd0, ferr1}, {31'd0, e.ferr});
        end
      end
      if (done2) begin
        check("d2_pulse_width", {31'd0, prev2}, 32'd0);
        check("d2_done_expected", {31'd0, q2.size() != 0}, 32'd1);
        if (q2.size() != 0) begin
          e = q2.pop_front();
          check("d2_data", {24'd0, data2}, {24'd0, e.data});
          check("d2_perr", {31'd0, perr2}, {31'd0, e.perr});
          check("d2_ferr", {31'd0, ferr2}, {31'd0, e.ferr});
        end
      end
    end
    prev0 <= done0;
    prev1 <= done1;
    prev2 <= done2;
  end

  task automatic drive_bit(input int which, input logic v);
    case (which)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                            input logic par, input logic s1, input bit two_stop, input logic s2);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (has_par) drive_bit(which, par);
    drive_bit(which, s1);
    if (two_stop) drive_bit(which, s2);
    case (which)
      0:       rx0 = 1'b1;
      1:       rx1 = 1'b1;
      default: rx2 = 1'b1;
    endcase
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  initial begin
    // Reset state of all three instances.
    repeat (3) @(negedge clk);
    check("rst_outs_d0", {20'd0, done0, data0, perr0, ferr0, busy0}, 32'd0);
    check("rst_outs_d1", {20'd0, done1, data1, perr1, ferr1, busy1}, 32'd0);
    check("rst_outs_d2", {20'd0, done2, data2, perr2, ferr2, busy2}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // 8N1 basic frame.
    q0.push_back(mk(8'hA5, 1'b0, 1'b0));
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    check("d0_idle_after_a5", {31'd0, busy0}, 32'd0);

    // Low glitch of 4 ticks on the idle line: start is rejected.
    rx0 = 1'b0;
    repeat (6) @(negedge clk);
    check("glitch_busy_seen", {31'd0, busy0}, 32'd1);
    repeat (2) @(negedge clk);
    rx0 = 1'b1;
    repeat (16) @(negedge clk);
    check("glitch_busy_clear", {31'd0, busy0}, 32'd0);
    check("glitch_data_hold", {24'd0, data0}, 32'h0000_00A5);
    idle_bits(2);

    // Even parity: 0x37 has five ones, correct parity bit is 1.
    q1.push_back(mk(8'h37, 1'b1, 1'b0));
    send_frame(1, 8'h37, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_bits(2);
    q1.push_back(mk(8'h37, 1'b0, 1'b0));
    send_frame(1, 8'h37, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_bits(2);

    // Two stop bits, second one low: framing error, data still delivered.
    q2.push_back(mk(8'h5A, 1'b0, 1'b1));
    send_frame(2, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    q2.push_back(mk(8'hA5, 1'b0, 1'b0));
    send_frame(2, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_bits(2);

    // Back-to-back frames with no idle gap.
    q0.push_back(mk(8'h00, 1'b0, 1'b0));
    q0.push_back(mk(8'hFF, 1'b0, 1'b0));
    q0.push_back(mk(8'h81, 1'b0, 1'b0));
    send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_bits(2);

    // Break: one frame of zeros with framing error, then no re-trigger until line is high.
    q0.push_back(mk(8'h00, 1'b0, 1'b1));
    rx0 = 1'b0;
    idle_bits(12);
    rx0 = 1'b1;
    idle_bits(2);
    check("break_busy_clear", {31'd0, busy0}, 32'd0);
    q0.push_back(mk(8'h42, 1'b0, 1'b0));
    send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_bits(2);

    // Reset in the middle of the data bits of 0x3C: partial frame dropped.
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    check("midframe_busy", {31'd0, busy0}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_outs_async", {20'd0, done0, data0, perr0, ferr0, busy0}, 32'd0);
    rx0 = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_outs_hold", {20'd0, done0, data0, perr0, ferr0, busy0}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);
    check("postrst_data_zero", {24'd0, data0}, 32'd0);
    q0.push_back(mk(8'hC3, 1'b0, 1'b0));
    send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle_bits(3);
    check("final_data_c3", {24'd0, data0}, 32'h0000_00C3);

    // Every queued frame must have produced its done pulse.
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
